// File: rtl/id_ex_stage_if.sv
// Bus between decode/forwarding and the ID/EX pipeline register.
// slave = the id_ex_stage register itself; master = whatever drives decode/forwarding and consumes EX.
interface id_ex_stage_if;
  // Decode side
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [1:0]  id_inst_type;
  logic        id_ready;

  // Register file and forwarding unit
  logic [31:0] rf_dat_a;
  logic [31:0] rf_dat_b;
  logic        fwd_A;
  logic        fwd_B;
  logic [31:0] dat_A;
  logic [31:0] dat_B;
  logic        fwd_stall;

  // EX side
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_inst_type;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;

  // Monitoring / debug
  logic [15:0] stall_cycles;
  logic [1:0]  slot_state;

  modport slave (
    input  id_valid, id_pc, id_inst, id_rs1, id_rs2, id_rd, id_inst_type,
    input  rf_dat_a, rf_dat_b, fwd_A, fwd_B, dat_A, dat_B, fwd_stall,
    input  flush, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_inst, ex_rs1, ex_rs2, ex_rd,
    output ex_inst_type, ex_op_a, ex_op_b, stall_cycles, slot_state
  );

  modport master (
    output id_valid, id_pc, id_inst, id_rs1, id_rs2, id_rd, id_inst_type,
    output rf_dat_a, rf_dat_b, fwd_A, fwd_B, dat_A, dat_B, fwd_stall,
    output flush, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_inst, ex_rs1, ex_rs2, ex_rd,
    input  ex_inst_type, ex_op_a, ex_op_b, stall_cycles, slot_state
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding mux, stall bubbles, branch flush.
// Optional stall monitor counter is built only when ID_EX_STALL_MON_EN is defined.
module id_ex_stage #(
  parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst,
  id_ex_stage_if.slave bus
);

  // Handshake: decode offers an instruction with id_valid; it is consumed on a
  // rising edge only when id_ready is high in that cycle. EX consumes the slot
  // on an edge where ex_valid & ex_ready; while ex_valid & ~ex_ready the slot
  // is frozen (HELD) unless a flush or reset discards it.

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_FULL  = 2'd1,
    SLOT_HELD  = 2'd2
  } slot_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  inst_type;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } ex_slot_t;

  // A bubble must carry rd=0 and type=00 so the forwarding unit's x0 compare stays quiet.
  function automatic ex_slot_t bubble_slot();
    ex_slot_t s;
    s           = '0;
    s.inst      = RESET_INST;
    s.inst_type = 2'b00;
    return s;
  endfunction

  ex_slot_t    slot_q;
  ex_slot_t    slot_d;
  ex_slot_t    capture_slot;
  slot_state_t slot_state;

  logic        advance;
  logic [31:0] op_a;
  logic [31:0] op_b;

  // Operand selection, evaluated fresh in whichever cycle the capture happens
  always_comb begin
    op_a = bus.fwd_A ? bus.dat_A : bus.rf_dat_a;
    op_b = bus.fwd_B ? bus.dat_B : bus.rf_dat_b;
  end

  assign advance      = ~slot_q.valid | bus.ex_ready;
  assign bus.id_ready = bus.id_valid & ~bus.fwd_stall & ~bus.flush & advance;

  always_comb begin
    capture_slot           = '0;
    capture_slot.valid     = 1'b1;
    capture_slot.pc        = bus.id_pc;
    capture_slot.inst      = bus.id_inst;
    capture_slot.rs1       = bus.id_rs1;
    capture_slot.rs2       = bus.id_rs2;
    capture_slot.rd        = bus.id_rd;
    capture_slot.inst_type = bus.id_inst_type;
    capture_slot.op_a      = op_a;
    capture_slot.op_b      = op_b;
  end

  // Next-slot selection; order here is the edge priority
  always_comb begin
    slot_d = slot_q;
    if (bus.flush) begin
      slot_d = bubble_slot();
    end else if (!advance) begin
      slot_d = slot_q;
    end else if (bus.fwd_stall || !bus.id_valid) begin
      slot_d = bubble_slot();
    end else begin
      slot_d = capture_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= bubble_slot();
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    slot_state = SLOT_EMPTY;
    if (slot_q.valid) begin
      slot_state = bus.ex_ready ? SLOT_FULL : SLOT_HELD;
    end
  end

  assign bus.slot_state   = slot_state;
  assign bus.ex_valid     = slot_q.valid;
  assign bus.ex_pc        = slot_q.pc;
  assign bus.ex_inst      = slot_q.inst;
  assign bus.ex_rs1       = slot_q.rs1;
  assign bus.ex_rs2       = slot_q.rs2;
  assign bus.ex_rd        = slot_q.rd;
  assign bus.ex_inst_type = slot_q.inst_type;
  assign bus.ex_op_a      = slot_q.op_a;
  assign bus.ex_op_b      = slot_q.op_b;

`ifdef ID_EX_STALL_MON_EN
  logic [15:0] stall_cnt_q;
  logic        stall_event;

  // Counts decode stall requests even while the slot is HELD; a flush edge is not a stall
  assign stall_event = bus.id_valid & bus.fwd_stall & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else if (stall_event && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference slot model feeding an expected queue.
// Build with or without ID_EX_STALL_MON_EN; counter expectations follow the macro.
module tb_id_ex_stage;

  localparam int W = 146;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  id_ex_stage_if bus();

  id_ex_stage #(.RESET_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model;
  logic [W-1:0] got_slot;
  logic [W-1:0] exp_slot;
  logic         exp_ready;
  logic         got_ready;

  function automatic logic [W-1:0] bubble_vec();
    return {1'b0, 32'h0, NOP, 5'd0, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0};
  endfunction

  // Reference behaviour of the EX slot for the inputs currently driven
  function automatic logic [W-1:0] model_next(logic [W-1:0] cur);
    logic [31:0] a;
    logic [31:0] b;
    a = bus.fwd_A ? bus.dat_A : bus.rf_dat_a;
    b = bus.fwd_B ? bus.dat_B : bus.rf_dat_b;
    if (rst || bus.flush) return bubble_vec();
    if (cur[W-1] && !bus.ex_ready) return cur;
    if (bus.fwd_stall || !bus.id_valid) return bubble_vec();
    return {1'b1, bus.id_pc, bus.id_inst, bus.id_rs1, bus.id_rs2, bus.id_rd,
            bus.id_inst_type, a, b};
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    rst = 1'b0;
    bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_inst = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0; bus.id_inst_type = '0;
    bus.rf_dat_a = '0; bus.rf_dat_b = '0; bus.fwd_A = 1'b0; bus.fwd_B = 1'b0;
    bus.dat_A = '0; bus.dat_B = '0; bus.fwd_stall = 1'b0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1;
  endtask

  task automatic random_fields();
    bus.id_pc        = $urandom;
    bus.id_inst      = $urandom;
    bus.id_rs1       = 5'($urandom_range(0, 31));
    bus.id_rs2       = 5'($urandom_range(0, 31));
    bus.id_rd        = 5'($urandom_range(1, 31));
    bus.id_inst_type = 2'($urandom_range(0, 2));
    bus.rf_dat_a     = $urandom;
    bus.rf_dat_b     = $urandom;
    bus.dat_A        = $urandom;
    bus.dat_B        = $urandom;
    bus.fwd_A        = 1'($urandom_range(0, 1));
    bus.fwd_B        = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge
  task automatic step();
    logic [W-1:0] nxt;
    #1;
    exp_ready = bus.id_valid & ~bus.fwd_stall & ~bus.flush & (~model[W-1] | bus.ex_ready);
    got_ready = bus.id_ready;
    nxt = model_next(model);
    exp_q.push_back(nxt);
    model = nxt;
    @(posedge clk);
    #1;
    got_slot = {bus.ex_valid, bus.ex_pc, bus.ex_inst, bus.ex_rs1, bus.ex_rs2, bus.ex_rd,
                bus.ex_inst_type, bus.ex_op_a, bus.ex_op_b};
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_slot = exp_q.pop_front();
      checks++;
      if (got_slot !== exp_slot) $display("FAIL reset_slot got=%h exp=%h", got_slot, exp_slot);
      else passed++;
      checks++;
      if (got_ready !== 1'b0) $display("FAIL reset_id_ready got=%b exp=0", got_ready);
      else passed++;
    end
    checks++;
    if (bus.stall_cycles !== 16'h0000) $display("FAIL reset_stall_cycles got=%h exp=0000", bus.stall_cycles);
    else passed++;
    // Mid-operation reset discards a freshly captured slot
    rst = 1'b0; bus.id_valid = 1'b1; random_fields();
    step();
    rst = 1'b1; random_fields();
    step();
    for (int i = 0; i < 2; i++) begin
      exp_slot = exp_q.pop_front();
      if (i == 1) begin
        checks++;
        if (got_slot !== exp_slot) $display("FAIL reset_mid_op got=%h exp=%h", got_slot, exp_slot);
        else passed++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_forward_select();
    idle_inputs();
    bus.id_valid = 1'b1; bus.id_pc = 32'h0000_1000; bus.id_inst = 32'h0020_81B3;
    bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_rd = 5'd3; bus.id_inst_type = 2'b00;
    bus.fwd_A = 1'b1; bus.dat_A = 32'hDEAD_BEEF; bus.rf_dat_a = 32'h1111_1111;
    bus.fwd_B = 1'b0; bus.dat_B = 32'h5555_5555; bus.rf_dat_b = 32'h2222_2222;
    step();
    exp_slot = exp_q.pop_front();
    checks++;
    if (got_slot !== exp_slot) $display("FAIL fwd_select_slot got=%h exp=%h", got_slot, exp_slot);
    else passed++;
    checks++;
    if (bus.ex_op_a !== 32'hDEAD_BEEF || bus.ex_op_b !== 32'h2222_2222)
      $display("FAIL fwd_select_ops got=%h/%h exp=deadbeef/22222222", bus.ex_op_a, bus.ex_op_b);
    else passed++;
    checks++;
    if (got_ready !== 1'b1) $display("FAIL fwd_select_id_ready got=%b exp=1", got_ready);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      random_fields();
      step();
      exp_slot = exp_q.pop_front();
      checks++;
      if (got_slot !== exp_slot) $display("FAIL fwd_random_%0d got=%h exp=%h", i, got_slot, exp_slot);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_load_use_stall();
    logic [15:0] exp_cnt;
    idle_inputs();
    rst = 1'b1;
    step();
    void'(exp_q.pop_front());
    rst = 1'b0; bus.id_valid = 1'b1; bus.fwd_stall = 1'b1; bus.ex_ready = 1'b1;
    random_fields();
    for (int i = 0; i < 2; i++) begin
      step();
      exp_slot = exp_q.pop_front();
      checks++;
      if (got_slot !== exp_slot) $display("FAIL stall_bubble_%0d got=%h exp=%h", i, got_slot, exp_slot);
      else passed++;
      checks++;
      if (got_ready !== 1'b0) $display("FAIL stall_id_ready_%0d got=%b exp=0", i, got_ready);
      else passed++;
    end
`ifdef ID_EX_STALL_MON_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    checks++;
    if (bus.stall_cycles !== exp_cnt) $display("FAIL stall_cycles got=%0d exp=%0d", bus.stall_cycles, exp_cnt);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_hold();
    idle_inputs();
    bus.id_valid = 1'b1; random_fields(); bus.id_rd = 5'd5;
    step();
    exp_slot = exp_q.pop_front();
    checks++;
    if (got_slot !== exp_slot) $display("FAIL hold_capture got=%h exp=%h", got_slot, exp_slot);
    else passed++;
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      random_fields();
      bus.fwd_stall = (i % 2 == 0);
      step();
      exp_slot = exp_q.pop_front();
      checks++;
      if (got_slot !== exp_slot) $display("FAIL hold_frozen_%0d got=%h exp=%h", i, got_slot, exp_slot);
      else passed++;
      checks++;
      if (got_ready !== 1'b0) $display("FAIL hold_id_ready_%0d got=%b exp=0", i, got_ready);
      else passed++;
    end
    checks++;
    if (bus.ex_rd !== 5'd5 || bus.slot_state !== 2'd2)
      $display("FAIL hold_rd_state got=%0d/%0d exp=5/2", bus.ex_rd, bus.slot_state);
    else passed++;
    bus.ex_ready = 1'b1; bus.fwd_stall = 1'b0; random_fields();
    step();
    exp_slot = exp_q.pop_front();
    checks++;
    if (got_slot !== exp_slot) $display("FAIL hold_release got=%h exp=%h", got_slot, exp_slot);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_flush();
    idle_inputs();
    bus.id_valid = 1'b1; random_fields();
    step();
    bus.id_valid = 1'b0; bus.ex_ready = 1'b0;
    step();
    bus.id_valid = 1'b1; bus.flush = 1'b1; random_fields();
    step();
    for (int i = 0; i < 3; i++) begin
      exp_slot = exp_q.pop_front();
      checks++;
      if (got_slot !== exp_slot && i == 2) $display("FAIL flush_held got=%h exp=%h", got_slot, exp_slot);
      else if (i == 2) passed++;
      else checks--;
    end
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_inst !== NOP)
      $display("FAIL flush_bubble got=%b/%h exp=0/%h", bus.ex_valid, bus.ex_inst, NOP);
    else passed++;
    checks++;
    if (got_ready !== 1'b0) $display("FAIL flush_id_ready got=%b exp=0", got_ready);
    else passed++;
    bus.fwd_stall = 1'b1; bus.ex_ready = 1'b1;
    step();
    exp_slot = exp_q.pop_front();
    checks++;
    if (got_slot !== exp_slot) $display("FAIL flush_with_stall got=%h exp=%h", got_slot, exp_slot);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int errs;
    errs = 0;
    idle_inputs();
    for (int i = 0; i < 200; i++) begin
      random_fields();
      bus.id_valid  = ($urandom_range(0, 3) != 0);
      bus.fwd_stall = ($urandom_range(0, 4) == 0);
      bus.flush     = ($urandom_range(0, 9) == 0);
      bus.ex_ready  = ($urandom_range(0, 2) != 0);
      step();
      exp_slot = exp_q.pop_front();
      checks++;
      if (got_slot !== exp_slot) begin
        if (errs < 10) $display("FAIL b2b_slot_%0d got=%h exp=%h", i, got_slot, exp_slot);
        errs++;
      end else passed++;
      checks++;
      if (got_ready !== exp_ready) begin
        if (errs < 10) $display("FAIL b2b_id_ready_%0d got=%b exp=%b", i, got_ready, exp_ready);
        errs++;
      end else passed++;
    end
    idle_inputs();
  endtask

`ifdef ID_EX_STALL_MON_EN
  task automatic test_saturation();
    idle_inputs();
    rst = 1'b1;
    step();
    void'(exp_q.pop_front());
    rst = 1'b0; bus.id_valid = 1'b1; bus.fwd_stall = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    @(negedge clk);
    model = bubble_vec();
    checks++;
    if (bus.stall_cycles !== 16'hFFFF) $display("FAIL sat_count got=%h exp=ffff", bus.stall_cycles);
    else passed++;
    rst = 1'b1;
    step();
    exp_slot = exp_q.pop_front();
    checks++;
    if (got_slot !== exp_slot) $display("FAIL sat_reset_slot got=%h exp=%h", got_slot, exp_slot);
    else passed++;
    checks++;
    if (bus.stall_cycles !== 16'h0000) $display("FAIL sat_reset_count got=%h exp=0000", bus.stall_cycles);
    else passed++;
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    model = bubble_vec();
    @(negedge clk);
    test_reset();
    test_forward_select();
    test_load_use_stall();
    test_hold();
    test_flush();
    test_back_to_back();
`ifdef ID_EX_STALL_MON_EN
    test_saturation();
`endif
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    else passed++;
    // Final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register that sits directly downstream of the forwarding unit. Each cycle it selects each source operand from either the register file or the forwarded value, and captures the decoded instruction into the EX slot. It inserts a bubble when the forwarding unit requests a stall and applies branch flushes from EX. Its EX-slot outputs (ex_rd, ex_inst_type) feed back to the forwarding unit's EX_rd/EX_inst inputs.

## Interface
- RESET_INST, 32'h0000_0013, instruction word loaded on reset, flush and bubble (addi x0,x0,0)
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_pc  in  32  decode PC
- id_inst  in  32  decode instruction word
- id_rs1, id_rs2, id_rd  in  5 each  decoded register indices
- id_inst_type  in  2  00 = result ready in EX, 01 = load (ready in MEM), 10 = ready in WB
- rf_dat_a, rf_dat_b  in  32 each  register-file read data
- fwd_A, fwd_B  in  1 each  forwarding-unit mux selects
- dat_A, dat_B  in  32 each  forwarded data
- fwd_stall  in  1  forwarding-unit stall request
- flush  in  1  taken branch/jump resolved in EX
- ex_ready  in  1  EX stage accepts the current slot this cycle
- id_ready  out  1  decode instruction consumed this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_inst  out  32 each  registered PC and instruction
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
- ex_inst_type  out  2  registered type
- ex_op_a, ex_op_b  out  32 each  registered resolved operands
- stall_cycles  out  16  stall counter (see Configuration)

## Operation
- op_a = fwd_A ? dat_A : rf_dat_a; op_b = fwd_B ? dat_B : rf_dat_b. The selection is combinational, evaluated in the capture cycle.
- advance = ~ex_valid | ex_ready.
- id_ready = id_valid & ~fwd_stall & ~flush & advance.
- Priority on each rising edge:
  1. rst: load bubble.
  2. flush: load bubble. The decode instruction is dropped, and id_ready is 0.
  3. ~advance: hold all EX outputs unchanged.
  4. fwd_stall or ~id_valid: load bubble.
  5. Otherwise load the decode fields, ex_valid=1.
- Bubble contents:
  - ex_valid=0, ex_inst=RESET_INST, ex_pc=0.
  - ex_rs1=ex_rs2=ex_rd=0, ex_inst_type=2'b00, ex_op_a=ex_op_b=0.
  - ex_inst_type must be 00 with ex_rd=0. Otherwise the forwarding unit's unguarded rs==EX_rd compare on x0 raises a false stall.
- Effective slot states:
  - EMPTY (ex_valid=0): always advances.
  - FULL (ex_valid=1, ex_ready=1): advances.
  - HELD (ex_valid=1, ex_ready=0): frozen until ex_ready or flush.
- Simultaneous events:
  - fwd_stall with HELD: hold, no bubble.
  - flush with HELD: flush wins.
  - fwd_stall with flush: bubble.

## Timing
- Latency: one cycle from decode to EX outputs.
- Outputs are registered, except id_ready, which is combinational from same-cycle inputs.
- Reset values: every output 0, except ex_inst=RESET_INST, ex_inst_type=00, and id_ready as derived (0 while ex_valid=0 and id_valid=0).
- Reset asserted mid-operation discards the EX slot on that edge. stall_cycles also clears.
- Forwarded data is sampled on the capture edge. A stall cycle re-evaluates the mux on the following cycle with fresh dat_A/dat_B.

## Configuration
- ID_EX_STALL_MON_EN defined:
  - stall_cycles increments by 1 on each edge where id_valid & fwd_stall & ~flush & ~rst.
  - It saturates at 16'hFFFF and does not wrap.
  - It clears on rst.
- Undefined: no counter register is built, and stall_cycles is tied to 16'h0000.

## Test plan
- Reset: rst high 2 cycles -> ex_valid=0, ex_inst=32'h0000_0013, ex_rd=0, ex_inst_type=00, stall_cycles=0.
- Forward select: id_valid=1, fwd_A=1, dat_A=32'hDEAD_BEEF, rf_dat_a=32'h1111_1111, fwd_B=0, rf_dat_b=32'h2222_2222, ex_ready=1 -> next cycle ex_op_a=32'hDEAD_BEEF, ex_op_b=32'h2222_2222, ex_valid=1, id_ready was 1.
- Load-use stall: fwd_stall=1 for 2 cycles, ex_ready=1 -> bubble each cycle (ex_valid=0, ex_rd=0, ex_inst_type=00), id_ready=0, stall_cycles=2 with ID_EX_STALL_MON_EN, 0 without.
- Hold: slot valid with ex_rd=5, ex_ready=0 for 3 cycles, fwd_stall toggling -> ex_* unchanged, id_ready=0. Then ex_ready=1 -> next instruction captured.
- Flush priority: slot HELD plus flush=1 plus id_valid=1 -> next cycle ex_valid=0, ex_inst=RESET_INST, id_ready=0 during the flush cycle.
- Saturation (macro defined): force 65540 stall cycles -> stall_cycles=16'hFFFF, no wrap. Then rst -> 0.
